// File: rtl/mips_alu_if.sv
// Operand/result bundle between instruction decode and the ALU.
// Decode drives operands and opcode; the ALU returns a registered result with flags.
interface mips_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dest;
  logic [3:0]       aluopcode;
  logic             in_valid;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             zero;
  logic             overflow;

  modport master (
    output src, dest, aluopcode, in_valid,
    input  res, res_valid, zero, overflow
  );

  modport slave (
    input  src, dest, aluopcode, in_valid,
    output res, res_valid, zero, overflow
  );
endinterface

// File: rtl/mips_alu.sv
// Integer ALU for the MIPS-subset core: add/sub/logic/compare/shift.
// The result and flags are registered, so they appear one cycle after issue.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mips_alu_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;
  logic             r_valid;

  assign w_sum   = bus.src + bus.dest;
  assign w_diff  = bus.src - bus.dest;
  assign w_shamt = bus.dest[SHW-1:0];

  // Reserved opcodes fall into the default arm and produce a clean 0.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.aluopcode)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.src[WIDTH-1] == bus.dest[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.src[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (bus.src[WIDTH-1] != bus.dest[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.src[WIDTH-1]);
      end
      OP_AND:  w_res = bus.src & bus.dest;
      OP_OR:   w_res = bus.src | bus.dest;
      OP_NOR:  w_res = ~(bus.src | bus.dest);
      OP_XOR:  w_res = bus.src ^ bus.dest;
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.src < bus.dest)};
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src) < $signed(bus.dest))};
      OP_SLL:  w_res = bus.src << w_shamt;
      OP_SRL:  w_res = bus.src >> w_shamt;
      OP_SRA:  w_res = WIDTH'($signed(bus.src) >>> w_shamt);
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Idle cycles hold the last result and flags; only the valid strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_res  <= w_res;
        r_zero <= (w_res == '0);
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.res       = r_res;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;
  assign bus.res_valid = r_valid;
endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: hand-computed vectors checked one cycle after issue.
module tb_mips_alu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_alu_if #(.WIDTH(32)) u_if ();

  mips_alu #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_res, input logic e_zero,
                         input logic e_ovf, input logic e_valid);
    chk({tag, ".res"},       u_if.res,               e_res);
    chk({tag, ".zero"},      {31'b0, u_if.zero},      {31'b0, e_zero});
    chk({tag, ".overflow"},  {31'b0, u_if.overflow},  {31'b0, e_ovf});
    chk({tag, ".res_valid"}, {31'b0, u_if.res_valid}, {31'b0, e_valid});
  endtask

  // Drive at the falling edge, let the rising edge capture, sample 1 ns later.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.aluopcode = op;
    u_if.src       = a;
    u_if.dest      = b;
    u_if.in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.aluopcode = op;
    u_if.src       = a;
    u_if.dest      = b;
    u_if.in_valid  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    u_if.src       = '0;
    u_if.dest      = '0;
    u_if.aluopcode = 4'b0000;
    u_if.in_valid  = 1'b0;
    #12;
    chk_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);

    idle(4'b0001, 32'h1234_5678, 32'h1234_5678);
    chk_all("hold", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    issue(4'b0001, 32'h0000_0005, 32'h0000_0005);
    chk_all("sub_zero", 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b0001, 32'h8000_0000, 32'h0000_0001);
    chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    issue(4'b0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk_all("sub_ovf_pos", 32'h8000_0000, 1'b0, 1'b1, 1'b1);

    issue(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_all("add_negneg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);

    issue(4'b0000, 32'h8000_0000, 32'h8000_0000);
    chk_all("add_wrap", 32'h0, 1'b1, 1'b1, 1'b1);

    issue(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_all("slt", 32'h1, 1'b0, 1'b0, 1'b1);

    issue(4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_all("sltu", 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b1010, 32'h8000_0000, 32'h0000_0024);
    chk_all("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b1);

    issue(4'b1001, 32'h8000_0000, 32'h0000_0024);
    chk_all("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b1);

    issue(4'b1000, 32'h0000_0001, 32'h0000_001F);
    chk_all("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFE0);
    chk_all("sra_by0", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    issue(4'b0010, 32'hF0F0_FFFF, 32'h0FF0_0F0F);
    chk_all("and", 32'h00F0_0F0F, 1'b0, 1'b0, 1'b1);

    issue(4'b0011, 32'hF000_0000, 32'h0000_000F);
    chk_all("or", 32'hF000_000F, 1'b0, 1'b0, 1'b1);

    issue(4'b0110, 32'hFFFF_0000, 32'h0F0F_0F0F);
    chk_all("xor", 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b1);

    issue(4'b0101, 32'h0F0F_0000, 32'h0000_0F0F);
    chk_all("nor", 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b1);

    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_all("add_ovf2", 32'h8000_0000, 1'b0, 1'b1, 1'b1);

    issue(4'b1111, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_all("rsv_1111", 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_all("rsv_0111", 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b1100, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_all("rsv_1100", 32'h0, 1'b1, 1'b0, 1'b1);

    issue(4'b0000, 32'h0000_0010, 32'h0000_0020);
    chk_all("add_pre_rst", 32'h0000_0030, 1'b0, 1'b0, 1'b1);

    // Reset asserted between edges while an op is being presented.
    @(negedge clk);
    u_if.aluopcode = 4'b0001;
    u_if.src       = 32'h0000_0100;
    u_if.dest      = 32'h0000_0001;
    u_if.in_valid  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst            = 1'b0;
    u_if.aluopcode = 4'b0000;
    u_if.src       = 32'h0000_0003;
    u_if.dest      = 32'h0000_0004;
    u_if.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h0000_0007, 1'b0, 1'b0, 1'b1);

    idle(4'b0000, 32'h0, 32'h0);
    chk_all("post_idle", 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
